// File: rtl/mc_mem_responder.sv
// ---------------------------------------------------------------------------
// mc_mem_responder
//
// Memory-side responder for the multi-cycle CPU. Takes one request at a time
// from the controller/datapath, waits a fixed number of wait states, then
// issues a one-cycle Done strobe with read data (or performs a byte-masked
// write). WBType reports the byte offset of the last accepted address so the
// controller can steer lwl/lwr/swl/swr lanes.
//
// Parameters
//   ADDR_W       word-address bits; RAM depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports
//   Clk             in   1   rising-edge clock
//   Reset           in   1   synchronous, active-high reset
//   Req_valid       in   1   request present
//   Req_ready       out  1   responder can accept (accept = Req_valid & Req_ready)
//   Addr            in   32  byte address; word index = Addr[ADDR_W+1:2]
//   Mem_byte_write  in   4   byte-lane write mask, [3] -> bits 31:24; 0 = read
//   Wdata           in   32  lane-aligned write data
//   Done            out  1   one-cycle response strobe
//   Rdata           out  32  read word while Done; zero on error or write
//   WBType          out  2   Addr[1:0] of the last accepted request
//   Addr_err        out  1   with Done: address above the RAM, nothing written
//   Busy            out  1   inverse of Req_ready
// ---------------------------------------------------------------------------
module mc_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic [31:0] Addr,
    input  logic [3:0]  Mem_byte_write,
    input  logic [31:0] Wdata,
    output logic        Done,
    output logic [31:0] Rdata,
    output logic [1:0]  WBType,
    output logic        Addr_err,
    output logic        Busy
);

    localparam int DEPTH = 1 << ADDR_W;

    // Counter preload: the WAIT state is left when the counter reads zero,
    // so WAIT_CYCLES wait states need a preload of WAIT_CYCLES-1.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // Request captured at accept; everything after IDLE works from these.
    logic [ADDR_W-1:0] lat_idx;
    logic [3:0]        lat_mask;
    logic [31:0]       lat_wdata;
    logic              lat_err;

    logic              accept;
    logic              req_err;
    logic              resp_start;

    // Read-side selection: in IDLE the request is still on the inputs (this
    // matters when WAIT_CYCLES is 0 and RESP is entered straight from the
    // accept edge); otherwise the latched copy is used.
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_is_read;
    logic              rd_err;
    logic [31:0]       rd_word;
    logic              rd_ok;

    logic              wr_en;

    logic [31:0]       mem [DEPTH];

    assign accept  = Req_valid & Req_ready;
    assign req_err = |Addr[31:ADDR_W+2];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and response outputs
    // ------------------------------------------------------------------
    assign Req_ready = (state == S_IDLE);
    assign Busy      = ~Req_ready;
    assign Done      = (state == S_RESP);
    assign Addr_err  = Done & lat_err;
    assign Rdata     = rd_ok ? rd_word : 32'd0;

    assign resp_start = (state_nxt == S_RESP) && (state != S_RESP);

    always_comb begin
        rd_idx     = lat_idx;
        rd_is_read = (lat_mask == 4'd0);
        rd_err     = lat_err;
        if (state == S_IDLE) begin
            rd_idx     = Addr[ADDR_W+1:2];
            rd_is_read = (Mem_byte_write == 4'd0);
            rd_err     = req_err;
        end
    end

    // A write commits at the edge that ends RESP, unless Reset is asserted on
    // that same edge or the address was out of range.
    assign wr_en = (state == S_RESP) && !Reset && !lat_err && (lat_mask != 4'd0);

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            WBType    <= 2'd0;
            lat_idx   <= '0;
            lat_mask  <= 4'd0;
            lat_wdata <= 32'd0;
            lat_err   <= 1'b0;
            rd_ok     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                WBType    <= Addr[1:0];
                lat_idx   <= Addr[ADDR_W+1:2];
                lat_mask  <= Mem_byte_write;
                lat_wdata <= Wdata;
                lat_err   <= req_err;
            end
            // Only a clean read presents RAM data during RESP; the flag
            // drops again on the edge that leaves RESP.
            rd_ok <= resp_start && rd_is_read && !rd_err;
        end
    end

    // ------------------------------------------------------------------
    // Word RAM: byte-lane write port, registered read port
    // ------------------------------------------------------------------
    // NOTE: the RAM array has no reset branch; its contents survive Reset and
    // it maps onto plain memory macros without a clear path.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_mask[b]) begin
                    mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
                end
            end
        end
        // The read is captured on the edge that enters RESP; no write can
        // land between that edge and the end of the same RESP cycle.
        rd_word <= mem[rd_idx];
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mc_mem_responder
//
// Bench for mc_mem_responder. A WAIT_CYCLES=2 instance takes a directed
// vector table, reset-abort sequences and random traffic scored against an
// array-based memory model; a WAIT_CYCLES=0 instance takes back-to-back
// requests with Req_valid held high.
// ---------------------------------------------------------------------------
module tb_mc_mem_responder;

    localparam int ADDR_W = 8;
    localparam int WAITS  = 2;

    logic        clk;
    logic        reset;

    // WAIT_CYCLES = 2 instance
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [3:0]  mem_byte_write;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  wbtype;
    logic        addr_err;
    logic        busy;

    // WAIT_CYCLES = 0 instance
    logic        v0;
    logic        rdy0;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] d0;
    logic        done0;
    logic [31:0] rd0;
    logic [1:0]  wbt0;
    logic        err0;
    logic        busy0;

    int total = 0;
    int bad   = 0;

    mc_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITS)) dut (
        .Clk(clk), .Reset(reset),
        .Req_valid(req_valid), .Req_ready(req_ready),
        .Addr(addr), .Mem_byte_write(mem_byte_write), .Wdata(wdata),
        .Done(done), .Rdata(rdata), .WBType(wbtype),
        .Addr_err(addr_err), .Busy(busy)
    );

    mc_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
        .Clk(clk), .Reset(reset),
        .Req_valid(v0), .Req_ready(rdy0),
        .Addr(a0), .Mem_byte_write(m0), .Wdata(d0),
        .Done(done0), .Rdata(rd0), .WBType(wbt0),
        .Addr_err(err0), .Busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a plain word array updated by whole-request rules
    // ------------------------------------------------------------------
    logic [31:0] model_mem [1 << ADDR_W];

    task automatic model_apply(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                               output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        logic [31:0] w;
        exp_err = (a >> (ADDR_W + 2)) != 0;
        idx     = int'(a[ADDR_W+1:2]);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (m == 4'd0) begin
                exp_rd = model_mem[idx];
            end else begin
                w = model_mem[idx];
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) w[8*b +: 8] = d[8*b +: 8];
                end
                model_mem[idx] = w;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // One request on the WAIT_CYCLES=2 instance. Called at a negedge.
    // After the accept, Req_valid stays high and Addr/mask/Wdata are
    // scrambled; none of that may disturb the request in flight.
    // ------------------------------------------------------------------
    task automatic run_req(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                           output logic [31:0] got_rd, output logic got_err,
                           output logic [1:0] got_wbt);
        int g;
        int cycles;
        got_rd  = 32'hx;
        got_err = 1'bx;
        got_wbt = 2'bx;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        if (!req_ready) return;
        req_valid      = 1'b1;
        addr           = a;
        mem_byte_write = m;
        wdata          = d;
        @(posedge clk);
        #1;
        addr           = $urandom;
        wdata          = $urandom;
        mem_byte_write = 4'($urandom);
        cycles = 0;
        @(negedge clk);
        while (!done && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("latency", cycles, WAITS);
        check("busy_in_resp", {31'd0, busy}, 32'd1);
        got_rd  = rdata;
        got_err = addr_err;
        got_wbt = wbtype;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after_resp", {31'd0, req_ready}, 32'd1);
        check("wbtype_hold", {30'd0, wbtype}, {30'd0, a[1:0]});
    endtask

    task automatic req_and_score(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] exp_rd, got_rd;
        logic        exp_err, got_err;
        logic [1:0]  got_wbt;
        model_apply(a, m, d, exp_rd, exp_err);
        run_req(a, m, d, got_rd, got_err, got_wbt);
        check("rdata", got_rd, exp_rd);
        check("addr_err", {31'd0, got_err}, {31'd0, exp_err});
        check("wbtype", {30'd0, got_wbt}, {30'd0, a[1:0]});
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [1:0]  exp_wbt;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] got_rd, exp_rd, ra, rd_exp;
        logic        got_err, exp_err;
        logic [1:0]  got_wbt;
        int          npulse;
        logic [31:0] q_addr [6];
        logic [3:0]  q_mask [6];
        logic [31:0] q_data [6];
        logic [31:0] q_exp  [6];

        vecs[0]  = '{32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2'd0};
        vecs[1]  = '{32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2'd0};
        vecs[2]  = '{32'h0000_0012, 4'b1111, 32'h1122_3344, 32'h0000_0000, 1'b0, 2'd2};
        vecs[3]  = '{32'h0000_0012, 4'b0011, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 2'd2};
        vecs[4]  = '{32'h0000_0012, 4'b0000, 32'h0000_0000, 32'h1122_CCDD, 1'b0, 2'd2};
        vecs[5]  = '{32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 2'd0};
        vecs[6]  = '{32'h0000_4000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 2'd0};
        vecs[7]  = '{32'h0000_4000, 4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b1, 2'd0};
        vecs[8]  = '{32'h0000_0000, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 2'd0};
        vecs[9]  = '{32'h0000_0013, 4'b1000, 32'h5A00_0000, 32'h0000_0000, 1'b0, 2'd3};
        vecs[10] = '{32'h0000_0011, 4'b0000, 32'h0000_0000, 32'h5A22_CCDD, 1'b0, 2'd1};
        vecs[11] = '{32'h0000_0400, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 2'd0};
        vecs[12] = '{32'h0000_0003, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 2'd3};

        reset = 1'b1;
        req_valid = 1'b0; addr = '0; mem_byte_write = '0; wdata = '0;
        v0 = 1'b0; a0 = '0; m0 = '0; d0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_wbtype", {30'd0, wbtype}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            model_apply(vecs[i].addr, vecs[i].mask, vecs[i].wdata, exp_rd, exp_err);
            run_req(vecs[i].addr, vecs[i].mask, vecs[i].wdata, got_rd, got_err, got_wbt);
            check($sformatf("vec%0d_rdata", i), got_rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, got_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_wbt", i), {30'd0, got_wbt}, {30'd0, vecs[i].exp_wbt});
        end

        // Give every word a known value through the DUT
        for (int w = 0; w < (1 << ADDR_W); w++) begin
            req_and_score(32'(w * 4), 4'b1111, $urandom);
        end

        // Reset during WAIT of a write to word 8: aborted, no Done, no write
        req_valid = 1'b1; addr = 32'h20; mem_byte_write = 4'b1111; wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_wait_done", {31'd0, done}, 32'd0);
        check("abort_wait_ready", {31'd0, req_ready}, 32'd1);
        check("abort_wait_wbtype", {30'd0, wbtype}, 32'd0);
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("abort_wait_no_done", npulse, 0);
        req_and_score(32'h20, 4'b0000, 32'd0);

        // Reset coinciding with the RESP cycle of a write: not committed
        req_valid = 1'b1; addr = 32'h24; mem_byte_write = 4'b1111; wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        repeat (WAITS) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_resp_done_seen", {31'd0, done}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_resp_ready", {31'd0, req_ready}, 32'd1);
        check("abort_resp_done", {31'd0, done}, 32'd0);
        req_and_score(32'h24, 4'b0000, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ra = $urandom | (32'h400 << $urandom_range(0, 21));
            end else begin
                ra = 32'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 1) == 0)
                req_and_score(ra, 4'b0000, $urandom);
            else
                req_and_score(ra, 4'($urandom_range(0, 15)), $urandom);
        end

        // WAIT_CYCLES=0: Req_valid held high, requests back to back
        q_addr[0] = 32'h0; q_mask[0] = 4'b1111; q_data[0] = 32'h0102_0304; q_exp[0] = 32'h0;
        q_addr[1] = 32'h4; q_mask[1] = 4'b1111; q_data[1] = 32'hA0B0_C0D0; q_exp[1] = 32'h0;
        q_addr[2] = 32'h0; q_mask[2] = 4'b0000; q_data[2] = 32'h0;         q_exp[2] = 32'h0102_0304;
        q_addr[3] = 32'h4; q_mask[3] = 4'b0000; q_data[3] = 32'h0;         q_exp[3] = 32'hA0B0_C0D0;
        q_addr[4] = 32'h0; q_mask[4] = 4'b0000; q_data[4] = 32'h0;         q_exp[4] = 32'h0102_0304;
        q_addr[5] = 32'h4; q_mask[5] = 4'b0000; q_data[5] = 32'h0;         q_exp[5] = 32'hA0B0_C0D0;
        @(negedge clk);
        v0 = 1'b1;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b%0d_ready", i), {31'd0, rdy0}, 32'd1);
            check($sformatf("b2b%0d_idle_done", i), {31'd0, done0}, 32'd0);
            a0 = q_addr[i]; m0 = q_mask[i]; d0 = q_data[i];
            @(posedge clk);
            @(negedge clk);
            if (done0) npulse++;
            check($sformatf("b2b%0d_done", i), {31'd0, done0}, 32'd1);
            check($sformatf("b2b%0d_busy", i), {31'd0, busy0}, 32'd1);
            check($sformatf("b2b%0d_rdata", i), rd0, q_exp[i]);
            @(posedge clk);
            @(negedge clk);
        end
        v0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done0) npulse++;
            @(negedge clk);
        end
        check("b2b_pulse_count", npulse, 6);
        rd_exp = 32'd0;
        check("b2b_final_wbt", {30'd0, wbt0}, rd_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
